// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES helpers: S-box, xtime, MixColumns, Rcon seed, round-count derivation
package aes_pkg;

  typedef enum logic [2:0] {
    S_NOKEY,
    S_EXPAND,
    S_READY,
    S_ROUND,
    S_DONE
  } aes_state_e;

  // Forward S-box, entry 0x00 in the most significant byte
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [127:0] sb, sr, mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
    // byte index is 4*column+row; row r of column c comes from column (c+r) mod 4
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    state_out = (final_round ? sr : mc) ^ round_key;
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES-128/192/256 encryptor, one round per clock, key expanded once
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [3:0] NR_R    = 4'(NR);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_cipher_iter: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e   state, state_nx;
  logic [31:0]  w [NW];
  logic [5:0]   widx, rk_base;
  logic [2:0]   kcnt;
  logic [7:0]   rcon;
  logic [3:0]   round;
  logic [127:0] blk, rk, round_out;
  logic [31:0]  prev_w, temp_w, new_w;
  logic         key_fire, in_fire;

  assign key_fire = key_valid & key_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_data = blk;

  // Round 0 key is whitened in on acceptance; otherwise the current round selects the key
  assign rk_base = {(state == S_ROUND) ? round : 4'd0, 2'b00};
  assign rk = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};

  aes_round u_round (
    .state_in   (blk),
    .round_key  (rk),
    .final_round(round == NR_R),
    .state_out  (round_out)
  );

  // kcnt tracks i mod Nk so no divider is needed for the 192-bit schedule
  always_comb begin
    prev_w = w[widx - 6'd1];
    temp_w = prev_w;
    if (kcnt == 3'd0) temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && kcnt == 3'd4) temp_w = sub_word(prev_w);
    new_w = w[widx - NK_W] ^ temp_w;
  end

  always_ff @(posedge clk) begin
    if (key_fire) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[KEY_BITS-1-32*j -: 32];
    end else if (state == S_EXPAND) begin
      w[widx] <= new_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_NOKEY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_NOKEY: begin
        key_ready = 1'b1;
        if (key_valid) state_nx = S_EXPAND;
      end
      S_EXPAND: if (widx == LAST_W) state_nx = S_READY;
      S_READY: begin
        key_ready = 1'b1;
        in_ready  = ~key_valid;
        if (key_valid)     state_nx = S_EXPAND;
        else if (in_valid) state_nx = S_ROUND;
      end
      S_ROUND: if (round == NR_R) state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_READY;
      end
      default: state_nx = S_NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx  <= '0;
      kcnt  <= '0;
      rcon  <= '0;
      round <= '0;
      blk   <= '0;
    end else begin
      if (key_fire) begin
        widx <= NK_W;
        kcnt <= '0;
        rcon <= RCON_INIT;
      end else if (state == S_EXPAND) begin
        widx <= widx + 6'd1;
        kcnt <= (kcnt == NK_LAST) ? 3'd0 : kcnt + 3'd1;
        if (kcnt == 3'd0) rcon <= xtime(rcon);
      end
      if (in_fire) begin
        blk   <= in_data ^ rk;
        round <= 4'd1;
      end else if (state == S_ROUND) begin
        blk <= round_out;
        if (round != NR_R) round <= round + 4'd1;
      end
    end
  end

endmodule
